// File: rtl/venus_adder_pkg.sv
// Shared types and decode helpers for the pipelined add/subtract unit.
package venus_adder_pkg;

  typedef enum logic [1:0] {
    ADD_OP = 2'b00,
    SUB_OP = 2'b01,
    ADC_OP = 2'b10,
    SBB_OP = 2'b11
  } adder_op_t;

  // Subtracting ops invert operand b and report borrow instead of carry.
  function automatic logic op_is_sub(input adder_op_t op);
    return (op == SUB_OP) || (op == SBB_OP);
  endfunction

  // Carry into the lowest limb: SBB borrow-in becomes an inverted carry.
  function automatic logic op_cin(input adder_op_t op, input logic carry);
    case (op)
      ADD_OP:  return 1'b0;
      SUB_OP:  return 1'b1;
      ADC_OP:  return carry;
      default: return ~carry;
    endcase
  endfunction

endpackage

// File: rtl/adder_limb_stage.sv
// One registered limb of the carry chain: adds a limb with carry-in and
// folds the limb's zero test into the running zero flag.
module adder_limb_stage #(
  parameter int unsigned LIMB = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [LIMB-1:0] a,
  input  logic [LIMB-1:0] b,
  input  logic            cin,
  input  logic            zin,
  output logic [LIMB-1:0] sum,
  output logic            cout,
  output logic            zout
);

  logic [LIMB:0] total;

  // Limb add with carry-in, one bit wider to expose carry-out.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{LIMB{1'b0}}, cin};
  end

  // Capture limb sum, carry and accumulated zero when the stage advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      zout <= 1'b0;
    end else if (en) begin
      sum  <= total[LIMB-1:0];
      cout <= total[LIMB];
      zout <= zin & (total[LIMB-1:0] == '0);
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is split into STAGES limbs,
// one limb resolved per cycle, with a global-stall valid/ready handshake.
module adder_pipe
  import venus_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] opr0_i,
  input  logic [WIDTH-1:0] opr1_i,
  input  logic [1:0]       op_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_flag_o,
  output logic             pos_flag_o,
  output logic             neg_flag_o,
  output logic             overflow_flag_o,
  output logic             carry_flag_o
);

  localparam int unsigned LIMB = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic             stall;
  logic             accept;
  adder_op_t        op_new;
  logic [WIDTH-1:0] b_new;

  logic [STAGES-1:0] valid_in, valid_q, ld;
  logic [STAGES-1:0] cin_in, zin_in, cout_q, zout_q;
  adder_op_t         op_in [STAGES];
  adder_op_t         op_q  [STAGES];
  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_in   [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  res_in [STAGES];
  logic [WIDTH-1:0]  res_q  [STAGES];
  logic [WIDTH-1:0]  res_out[STAGES];
  logic [LIMB-1:0]   limb_sum[STAGES];
  logic              seen_q;

  assign valid_o = valid_q[LAST];
  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall & ~flush_i;
  assign accept  = valid_i & ready_o;
  assign op_new  = adder_op_t'(op_i);
  assign b_new   = opr1_i ^ {WIDTH{op_is_sub(op_new)}};

  // Steer each stage's inputs: stage 0 from the ports, later stages from the
  // previous stage's registers; a stage loads only real, unstalled, unflushed ops.
  always_comb begin
    valid_in = '0;
    cin_in   = '0;
    zin_in   = '0;
    ld       = '0;
    valid_in[0] = accept;
    op_in[0]    = op_new;
    a_in[0]     = opr0_i;
    b_in[0]     = b_new;
    cin_in[0]   = op_cin(op_new, carry_i);
    zin_in[0]   = 1'b1;
    res_in[0]   = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_in[k] = valid_q[k-1];
      op_in[k]    = op_q[k-1];
      a_in[k]     = a_q[k-1];
      b_in[k]     = b_q[k-1];
      cin_in[k]   = cout_q[k-1];
      zin_in[k]   = zout_q[k-1];
      res_in[k]   = res_out[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      ld[k] = valid_in[k] & ~stall & ~flush_i;
    end
  end

  // Merge each stage's freshly resolved limb into the lower result limbs.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      res_out[k] = res_q[k];
      res_out[k][k*LIMB +: LIMB] = limb_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_limb
    adder_limb_stage #(
      .LIMB(LIMB)
    ) u_limb (
      .clk  (clk_i),
      .rst  (rst_i),
      .en   (ld[k]),
      .a    (a_in[k][k*LIMB +: LIMB]),
      .b    (b_in[k][k*LIMB +: LIMB]),
      .cin  (cin_in[k]),
      .zin  (zin_in[k]),
      .sum  (limb_sum[k]),
      .cout (cout_q[k]),
      .zout (zout_q[k])
    );
  end

  // Stage valid shift register: flush kills everything, stall holds bubbles too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q <= valid_in;
    end
  end

  // Operands, partial result and op kind travel alongside the limb adders.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        op_q[k]  <= ADD_OP;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          op_q[k]  <= op_in[k];
          a_q[k]   <= a_in[k];
          b_q[k]   <= b_in[k];
          res_q[k] <= res_in[k];
        end
      end
    end
  end

  // Remembers that a result has been shown, so pos_flag stays 0 out of reset
  // even though the cleared result register has a zero sign bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seen_q <= 1'b0;
    end else if (valid_o) begin
      seen_q <= 1'b1;
    end
  end

  assign result_o        = res_out[LAST];
  assign zero_flag_o     = zout_q[LAST];
  assign neg_flag_o      = res_out[LAST][WIDTH-1];
  assign pos_flag_o      = (seen_q | valid_o) & ~res_out[LAST][WIDTH-1];
  assign overflow_flag_o = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                           (res_out[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
  assign carry_flag_o    = cout_q[LAST] ^ op_is_sub(op_q[LAST]);

endmodule
